ac_motor_gate_driver: RTL and testbench
=======================================

# ac_motor_gate_driver

Parametrised gate-driver stage that sits after the switch control in the AC-motor SVPWM chain. It converts requested leg states into complementary high-side/low-side gate signals with programmable dead time, for any phase count. It also enforces the one-leg-at-a-time transition rule in hardware: a violation latches a fault and forces every gate off.

## Interface
- `N_PHASES`, default 3: number of inverter legs.
- `DT_WIDTH`, default 8: width of the dead-time counter.
- `DEAD_TIME`, default 50: dead time in clk cycles. Legal range 1 to 2**DT_WIDTH-1.
- `STRICT`, default 1: 1 enables multi-leg transition fault detection; 0 disables it.
- `clk` input, 1 bit: system clock, all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: 1 runs the bridge; 0 forces all gates off.
- `s` input, N_PHASES bits: requested leg state per phase. 1 selects high side, 0 selects low side. Same encoding as s1/s2/s3.
- `fault_clr` input, 1 bit: synchronous clear of the latched fault.
- `gate_h` output, N_PHASES bits: high-side gate drive, registered.
- `gate_l` output, N_PHASES bits: low-side gate drive, registered.
- `dead` output, N_PHASES bits: 1 while the phase is in dead time, registered.
- `fault` output, 1 bit: sticky transition-violation flag.
- `fault_count` output, 8 bits: saturating count of violations.

## Operation
- Each phase has its own FSM with states OFF, DEAD, HIGH and LOW, plus a DT_WIDTH-bit down-counter.
- Gate outputs are decoded from the state and registered:
  - OFF: gate_h = 0, gate_l = 0.
  - DEAD: gate_h = 0, gate_l = 0, dead = 1.
  - HIGH: gate_h = 1.
  - LOW: gate_l = 1.
  - gate_h and gate_l are never 1 together.
- OFF → DEAD when en = 1 and fault = 0. The counter loads DEAD_TIME-1.
- LOW → DEAD when s[i] = 1. HIGH → DEAD when s[i] = 0. The counter loads DEAD_TIME-1.
- DEAD with counter ≠ 0: decrement. DEAD with counter = 0: go to HIGH if s[i] = 1 at that edge, else LOW.
  - Changes of s[i] during dead time do not restart the count.
  - Every dead interval is exactly DEAD_TIME cycles.
- en = 0 or fault = 1 forces all phases to OFF at the next edge, from any state. The counter is cleared.
- Violation detection:
  - `s_prev` holds s from the previous cycle; `en_q` holds en from the previous cycle. Both are reset to 0.
  - A violation is: STRICT = 1, en = 1, en_q = 1, and popcount(s ^ s_prev) > 1.
- On a violation:
  - fault is set.
  - fault_count increments and saturates at 255.
- fault stays set until fault_clr = 1 or reset. If a violation and fault_clr occur in the same cycle, the violation wins and fault stays 1.
- After the fault clears, phases leave OFF through a full DEAD interval.
- Reset values: every FSM in OFF, counters 0, gate_h = 0, gate_l = 0, dead = 0, fault = 0, fault_count = 0, s_prev = 0, en_q = 0.
- Reset mid-operation overrides everything, including an active dead count, in the cycle it is sampled.

## Timing
- All inputs are sampled at the rising edge of clk. No combinational path from inputs to outputs.
- Leg change request with s[i] toggled before edge k:
  - The old gate falls after edge k.
  - The new gate rises after edge k+DEAD_TIME.
  - Both gates are low for exactly DEAD_TIME cycles.
- Start-up: en rising before edge k, fault = 0. dead = 1 after edge k; the first gate is asserted after edge k+DEAD_TIME.
- Violation sampled at edge k:
  - fault = 1 after edge k.
  - All gates = 0 after edge k+1.
  - fault_count updates after edge k.
- fault_clr at edge k with no new violation: fault = 0 after edge k. DEAD is entered at edge k+1.

## Test plan
- **Start-up:** DEAD_TIME = 4, rst for 3 cycles, then en = 1, s = 3'b000 → all gates 0 for 4 cycles, then gate_l = 3'b111. gate_h stays 0. fault = 0.
- **Single-leg toggle:** s 000→001 at edge k → gate_l[0] = 0 after k, gate_h[0] = 1 after k+4. Other phases stay LOW. gate_h & gate_l = 0 on every cycle.
- **Glitch during dead time:** s[0] 0→1 at k, back to 0 at k+2 → dead[0] = 1 for exactly 4 cycles, then gate_l[0] = 1. gate_h[0] never asserts.
- **Violation:** s 000→011 in one cycle → fault = 1, fault_count = 1, all gates 0 one cycle later. A simultaneous fault_clr is ignored. A later fault_clr with stable s → a 4-cycle dead interval, then gates follow s.
- **STRICT = 0:** same 000→011 step → fault stays 0. Both legs go through independent 4-cycle dead intervals.
- **Reset and disable:**
  - rst asserted while phase 0 is 2 cycles into DEAD → all outputs 0 after that edge.
  - en = 0 while running → gates 0 on the next edge.
  - fault_count saturates at 255 after 300 forced violations.

Source files
------------

// File: rtl/ac_motor_gate_driver.sv
// Gate-driver stage: turns requested leg states into complementary high/low gate
// drives with a fixed dead time, and trips a sticky fault on multi-leg transitions.
module ac_motor_gate_driver #(
  parameter int N_PHASES  = 3,
  parameter int DT_WIDTH  = 8,
  parameter int DEAD_TIME = 50,
  parameter int STRICT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_PHASES-1:0] s,
  input  logic                fault_clr,
  output logic [N_PHASES-1:0] gate_h,
  output logic [N_PHASES-1:0] gate_l,
  output logic [N_PHASES-1:0] dead,
  output logic                fault,
  output logic [7:0]          fault_count
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // The counter reaches zero after DEAD_TIME-1 decrements, giving DEAD_TIME cycles in DEAD.
  localparam logic [DT_WIDTH-1:0] DT_LOAD = DT_WIDTH'(DEAD_TIME - 1);
  localparam int PCW = $clog2(N_PHASES + 1);

  logic [N_PHASES-1:0] s_prev;
  logic                en_q;
  logic [PCW-1:0]      n_diff;
  logic                violation;

  always_comb begin
    n_diff = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      n_diff = n_diff + PCW'(s[i] ^ s_prev[i]);
    end
  end

  assign violation = (STRICT != 0) && en && en_q && (n_diff > PCW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev      <= '0;
      en_q        <= 1'b0;
      fault       <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      s_prev <= s;
      en_q   <= en;
      // A violation in the same cycle as fault_clr keeps the fault set.
      fault  <= violation | (fault & ~fault_clr);
      if (violation && (fault_count != 8'hFF)) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < N_PHASES; i++) begin : g_phase
    logic [1:0]          state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                gh_q, gl_q, dd_q;

    // NOTE: defaults first so no path through this block leaves a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en || fault) begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_d = ST_DEAD;
            cnt_d   = DT_LOAD;
          end
          ST_LOW: begin
            if (s[i]) begin
              state_d = ST_DEAD;
              cnt_d   = DT_LOAD;
            end
          end
          ST_HIGH: begin
            if (!s[i]) begin
              state_d = ST_DEAD;
              cnt_d   = DT_LOAD;
            end
          end
          ST_DEAD: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - DT_WIDTH'(1);
            end else begin
              state_d = s[i] ? ST_HIGH : ST_LOW;
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        gh_q    <= 1'b0;
        gl_q    <= 1'b0;
        dd_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        gh_q    <= (state_d == ST_HIGH);
        gl_q    <= (state_d == ST_LOW);
        dd_q    <= (state_d == ST_DEAD);
      end
    end

    assign gate_h[i] = gh_q;
    assign gate_l[i] = gl_q;
    assign dead[i]   = dd_q;
  end

endmodule

// File: tb/tb_ac_motor_gate_driver.sv
// Bench for ac_motor_gate_driver: a strict and a non-strict instance share one
// stimulus stream and are compared every cycle against a remaining-cycles model.
module tb_ac_motor_gate_driver;

  localparam int NP = 3;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NP-1:0] s;
  logic          fault_clr;

  logic [NP-1:0] gh [2];
  logic [NP-1:0] gl [2];
  logic [NP-1:0] dd [2];
  logic          flt [2];
  logic [7:0]    fc [2];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ac_motor_gate_driver #(.N_PHASES(NP), .DT_WIDTH(8), .DEAD_TIME(DT), .STRICT(1)) u_strict (
    .clk(clk), .rst(rst), .en(en), .s(s), .fault_clr(fault_clr),
    .gate_h(gh[0]), .gate_l(gl[0]), .dead(dd[0]), .fault(flt[0]), .fault_count(fc[0])
  );

  ac_motor_gate_driver #(.N_PHASES(NP), .DT_WIDTH(8), .DEAD_TIME(DT), .STRICT(0)) u_loose (
    .clk(clk), .rst(rst), .en(en), .s(s), .fault_clr(fault_clr),
    .gate_h(gh[1]), .gate_l(gl[1]), .dead(dd[1]), .fault(flt[1]), .fault_count(fc[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: a leg is either idle, counting down remaining dead cycles, or driving a side.
  bit          m_act  [2][NP];
  int          m_left [2][NP];
  bit          m_side [2][NP];
  bit          m_fault [2];
  int          m_count [2];
  logic [NP-1:0] m_sprev = '0;
  bit          m_enq = 1'b0;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_fault[m] = 1'b0;
      m_count[m] = 0;
      for (int i = 0; i < NP; i++) begin
        m_act[m][i] = 1'b0; m_left[m][i] = 0; m_side[m][i] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_fault[m] = 1'b0;
        m_count[m] = 0;
        for (int i = 0; i < NP; i++) begin
          m_act[m][i] = 1'b0; m_left[m][i] = 0; m_side[m][i] = 1'b0;
        end
      end else begin
        bit viol;
        viol = (m == 0) && en && m_enq && ($countones(s ^ m_sprev) > 1);
        for (int i = 0; i < NP; i++) begin
          if (!en || m_fault[m]) begin
            m_act[m][i] = 1'b0; m_left[m][i] = 0; m_side[m][i] = 1'b0;
          end else if (!m_act[m][i]) begin
            m_act[m][i] = 1'b1; m_left[m][i] = DT;
          end else if (m_left[m][i] > 0) begin
            m_left[m][i] = m_left[m][i] - 1;
            if (m_left[m][i] == 0) m_side[m][i] = s[i];
          end else if (s[i] != m_side[m][i]) begin
            m_left[m][i] = DT;
          end
        end
        m_fault[m] = viol || (m_fault[m] && !fault_clr);
        if (viol && m_count[m] < 255) m_count[m] = m_count[m] + 1;
      end
    end
    if (rst) begin
      m_sprev = '0; m_enq = 1'b0;
    end else begin
      m_sprev = s; m_enq = en;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [NP-1:0] eh, el, ed;
        for (int i = 0; i < NP; i++) begin
          eh[i] = m_act[m][i] && (m_left[m][i] == 0) && m_side[m][i];
          el[i] = m_act[m][i] && (m_left[m][i] == 0) && !m_side[m][i];
          ed[i] = m_act[m][i] && (m_left[m][i] > 0);
        end
        check($sformatf("model_gate_h[%0d]", m), 32'(gh[m]), 32'(eh));
        check($sformatf("model_gate_l[%0d]", m), 32'(gl[m]), 32'(el));
        check($sformatf("model_dead[%0d]", m), 32'(dd[m]), 32'(ed));
        check($sformatf("model_fault[%0d]", m), 32'(flt[m]), 32'(m_fault[m]));
        check($sformatf("model_count[%0d]", m), 32'(fc[m]), 32'(m_count[m]));
        check($sformatf("no_overlap[%0d]", m), 32'(gh[m] & gl[m]), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = 3'b000; fault_clr = 1'b0;
    tick(1);
    cmp_en = 1'b1;
    check("reset_gates", 32'({gh[0], gl[0], dd[0]}), 32'd0);
    check("reset_fault", 32'({flt[0], fc[0]}), 32'd0);
    tick(2);

    // Start-up: four dead cycles, then all legs low.
    rst = 1'b0; en = 1'b1;
    tick(1);
    check("start_dead", 32'(dd[0]), 32'b111);
    tick(3);
    check("start_gl_before", 32'(gl[0]), 32'b000);
    tick(1);
    check("start_gl", 32'(gl[0]), 32'b111);
    check("start_gh", 32'(gh[0]), 32'b000);
    check("start_fault", 32'(flt[0]), 32'd0);

    // Single-leg toggle.
    s = 3'b001;
    tick(1);
    check("toggle_gl_fall", 32'(gl[0]), 32'b110);
    check("toggle_dead", 32'(dd[0]), 32'b001);
    tick(3);
    check("toggle_gh_wait", 32'(gh[0]), 32'b000);
    tick(1);
    check("toggle_gh_rise", 32'(gh[0]), 32'b001);
    check("toggle_gl_keep", 32'(gl[0]), 32'b110);

    // Glitch during dead time: count is not restarted, gate_h never asserts.
    s = 3'b000;
    tick(5);
    s = 3'b001;
    tick(2);
    s = 3'b000;
    tick(2);
    check("glitch_dead_k3", 32'(dd[0]), 32'b001);
    check("glitch_gh_k3", 32'(gh[0]), 32'b000);
    tick(1);
    check("glitch_gl", 32'(gl[0]), 32'b111);
    check("glitch_dead_end", 32'(dd[0]), 32'b000);
    tick(2);

    // Violation with simultaneous fault_clr.
    s = 3'b011; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("viol_fault", 32'(flt[0]), 32'd1);
    check("viol_count", 32'(fc[0]), 32'd1);
    check("loose_fault", 32'(flt[1]), 32'd0);
    tick(1);
    check("viol_gates_off", 32'({gh[0], gl[0], dd[0]}), 32'd0);
    tick(3);
    check("loose_gh", 32'(gh[1]), 32'b011);
    check("loose_gl", 32'(gl[1]), 32'b100);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("clr_fault", 32'(flt[0]), 32'd0);
    check("clr_gates_off", 32'(dd[0]), 32'b000);
    tick(1);
    check("clr_dead", 32'(dd[0]), 32'b111);
    tick(3);
    check("clr_dead_k3", 32'(dd[0]), 32'b111);
    tick(1);
    check("clr_gh", 32'(gh[0]), 32'b011);
    check("clr_gl", 32'(gl[0]), 32'b100);
    check("clr_count", 32'(fc[0]), 32'd1);

    // Reset two cycles into a dead interval.
    s = 3'b010;
    tick(2);
    check("pre_rst_dead", 32'(dd[0]), 32'b001);
    rst = 1'b1;
    tick(1);
    check("rst_outs", 32'({gh[0], gl[0], dd[0]}), 32'd0);
    check("rst_fault", 32'({flt[0], fc[0]}), 32'd0);
    rst = 1'b0;
    tick(1);
    check("restart_dead", 32'(dd[0]), 32'b111);
    tick(4);
    check("restart_gh", 32'(gh[0]), 32'b010);
    check("restart_gl", 32'(gl[0]), 32'b101);

    // Disable while running.
    en = 1'b0;
    tick(1);
    check("disable_off", 32'({gh[0], gl[0], dd[0]}), 32'd0);

    // Saturation of fault_count after 300 violations.
    en = 1'b1; s = 3'b000;
    tick(6);
    for (int k = 0; k < 300; k++) begin
      s = (k % 2 == 0) ? 3'b011 : 3'b000;
      tick(1);
    end
    check("sat_count", 32'(fc[0]), 32'd255);
    check("sat_fault", 32'(flt[0]), 32'd1);
    check("sat_loose_count", 32'(fc[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
